// File: rtl/aurora_init_pkg.sv
// Shared types and default timing constants for the Aurora channel bring-up sequencer.
package aurora_init_pkg;

  localparam int DEF_N_CH        = 2;
  localparam int DEF_GT_RST_CYC  = 128;
  localparam int DEF_SYS_RST_CYC = 256;
  localparam int DEF_UP_TIMEOUT  = 65536;
  localparam int DEF_STABLE_CYC  = 16;
  localparam int DEF_MAX_RETRY   = 3;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_GT_REL,
    ST_WAIT_UP,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } ch_state_e;

  typedef struct packed {
    logic gt_reset;
    logic reset_aurora;
    logic reset_txrx;
    logic link_ok;
    logic init_fail;
  } ch_out_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic ch_out_t ch_outputs(input ch_state_e s);
    ch_out_t o;
    o = '{gt_reset: 1'b1, reset_aurora: 1'b1, reset_txrx: 1'b1,
          link_ok: 1'b0, init_fail: 1'b0};
    case (s)
      ST_GT_REL:  o.gt_reset = 1'b0;
      ST_WAIT_UP,
      ST_STABLE: begin
        o.gt_reset     = 1'b0;
        o.reset_aurora = 1'b0;
      end
      ST_RUN: begin
        o.gt_reset     = 1'b0;
        o.reset_aurora = 1'b0;
        o.reset_txrx   = 1'b0;
        o.link_ok      = 1'b1;
      end
      ST_FAIL:    o.init_fail = 1'b1;
      default:    ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/aurora_init_ch.sv
// One Aurora channel: channel_up synchronizer plus reset/bring-up sequencer with retry.
module aurora_init_ch
  import aurora_init_pkg::*;
#(
  parameter int GT_RST_CYC  = DEF_GT_RST_CYC,
  parameter int SYS_RST_CYC = DEF_SYS_RST_CYC,
  parameter int UP_TIMEOUT  = DEF_UP_TIMEOUT,
  parameter int STABLE_CYC  = DEF_STABLE_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic init_clk,
  input  logic RST,
  input  logic channel_up,
  output logic gt_reset,
  output logic reset_Aurora,
  output logic reset_TX_RX_Block,
  output logic link_ok,
  output logic init_fail
);

  localparam int MAX_DUR = max2(max2(GT_RST_CYC, SYS_RST_CYC), max2(UP_TIMEOUT, STABLE_CYC));
  localparam int CW      = $clog2(MAX_DUR) + 1;
  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] GT_LAST     = CW'(GT_RST_CYC - 1);
  localparam logic [CW-1:0] SYS_LAST    = CW'(SYS_RST_CYC - 1);
  localparam logic [CW-1:0] UP_LAST     = CW'(UP_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  logic [1:0]    sync_q;
  logic          up_s;
  ch_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] retry, retry_nxt;
  ch_out_t       out_q, out_nxt;

  assign up_s = sync_q[1];

  // In STABLE, cnt holds the number of consecutive high cycles seen, including the entry cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry;
    case (state)
      ST_RESET: begin
        if (cnt == GT_LAST) begin
          state_nxt = ST_GT_REL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_GT_REL: begin
        if (cnt == SYS_LAST) begin
          state_nxt = ST_WAIT_UP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_WAIT_UP: begin
        if (up_s) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = CW'(1);
        end else if (cnt == UP_LAST) begin
          cnt_nxt = '0;
          if (retry < RETRY_MAX) begin
            retry_nxt = retry + RW'(1);
            state_nxt = ST_RESET;
          end else begin
            state_nxt = ST_FAIL;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_STABLE: begin
        if (!up_s) begin
          state_nxt = ST_WAIT_UP;
          cnt_nxt   = '0;
        end else if (cnt >= STABLE_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_RUN: begin
        if (!up_s) begin
          state_nxt = ST_RESET;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      end
      ST_FAIL: ;
      default: begin
        state_nxt = ST_RESET;
        cnt_nxt   = '0;
      end
    endcase
    out_nxt = ch_outputs(state_nxt);
  end

  always_ff @(posedge init_clk) begin
    if (RST) begin
      sync_q <= '0;
      state  <= ST_RESET;
      cnt    <= '0;
      retry  <= '0;
      out_q  <= ch_outputs(ST_RESET);
    end else begin
      sync_q <= {sync_q[0], channel_up};
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      retry  <= retry_nxt;
      out_q  <= out_nxt;
    end
  end

  assign gt_reset          = out_q.gt_reset;
  assign reset_Aurora      = out_q.reset_aurora;
  assign reset_TX_RX_Block = out_q.reset_txrx;
  assign link_ok           = out_q.link_ok;
  assign init_fail         = out_q.init_fail;

endmodule

// File: rtl/aurora_init_multi.sv
// Multi-channel Aurora initialisation: one independent sequencer per channel.
module aurora_init_multi
  import aurora_init_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int GT_RST_CYC  = DEF_GT_RST_CYC,
  parameter int SYS_RST_CYC = DEF_SYS_RST_CYC,
  parameter int UP_TIMEOUT  = DEF_UP_TIMEOUT,
  parameter int STABLE_CYC  = DEF_STABLE_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic            init_clk,
  input  logic            RST,
  input  logic [N_CH-1:0] channel_up,
  output logic [N_CH-1:0] gt_reset,
  output logic [N_CH-1:0] reset_Aurora,
  output logic [N_CH-1:0] reset_TX_RX_Block,
  output logic [N_CH-1:0] link_ok,
  output logic [N_CH-1:0] init_fail,
  output logic            all_link_ok
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    aurora_init_ch #(
      .GT_RST_CYC (GT_RST_CYC),
      .SYS_RST_CYC(SYS_RST_CYC),
      .UP_TIMEOUT (UP_TIMEOUT),
      .STABLE_CYC (STABLE_CYC),
      .MAX_RETRY  (MAX_RETRY)
    ) u_ch (
      .init_clk         (init_clk),
      .RST              (RST),
      .channel_up       (channel_up[i]),
      .gt_reset         (gt_reset[i]),
      .reset_Aurora     (reset_Aurora[i]),
      .reset_TX_RX_Block(reset_TX_RX_Block[i]),
      .link_ok          (link_ok[i]),
      .init_fail        (init_fail[i])
    );
  end

  assign all_link_ok = &link_ok;

endmodule

// File: tb/tb_aurora_init_multi.sv
// Directed bench for aurora_init_multi: bring-up, glitch, retry exhaustion, link drop, reset mid-run.
module tb_aurora_init_multi;

  logic       init_clk = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] channel_up = 2'b00;
  logic [1:0] gt_reset, reset_Aurora, reset_TX_RX_Block, link_ok, init_fail;
  logic       all_link_ok;

  int n_vec = 0;
  int n_bad = 0;
  int now   = 0;

  aurora_init_multi #(
    .N_CH       (2),
    .GT_RST_CYC (4),
    .SYS_RST_CYC(8),
    .UP_TIMEOUT (50),
    .STABLE_CYC (3),
    .MAX_RETRY  (2)
  ) dut (
    .init_clk         (init_clk),
    .RST              (RST),
    .channel_up       (channel_up),
    .gt_reset         (gt_reset),
    .reset_Aurora     (reset_Aurora),
    .reset_TX_RX_Block(reset_TX_RX_Block),
    .link_ok          (link_ok),
    .init_fail        (init_fail),
    .all_link_ok      (all_link_ok)
  );

  always #4 init_clk = ~init_clk;

  // Advance to 1 time unit after edge e (edge 1 = first edge with RST low).
  task automatic go_to(input int e);
    while (now < e) begin
      @(posedge init_clk);
      now++;
    end
    #1;
  endtask

  task automatic test_reset;
    repeat (50) @(posedge init_clk);
    #1;
    n_vec++;
    if ({gt_reset, reset_Aurora, reset_TX_RX_Block} !== 6'b111111) begin
      n_bad++; $display("FAIL reset_resets: got %b want 111111", {gt_reset, reset_Aurora, reset_TX_RX_Block});
    end
    n_vec++;
    if ({link_ok, init_fail, all_link_ok} !== 5'b00000) begin
      n_bad++; $display("FAIL reset_status: got %b want 00000", {link_ok, init_fail, all_link_ok});
    end
    RST = 1'b0;
    now = 0;
  endtask

  task automatic test_bringup_and_exhaust;
    go_to(3);
    n_vec++; if (gt_reset !== 2'b11) begin n_bad++; $display("FAIL gt_hold@3: got %b want 11", gt_reset); end
    go_to(4);
    n_vec++; if (gt_reset !== 2'b00) begin n_bad++; $display("FAIL gt_rel@4: got %b want 00", gt_reset); end
    n_vec++; if (reset_Aurora !== 2'b11) begin n_bad++; $display("FAIL aur_hold@4: got %b want 11", reset_Aurora); end
    go_to(11);
    n_vec++; if (reset_Aurora !== 2'b11) begin n_bad++; $display("FAIL aur_hold@11: got %b want 11", reset_Aurora); end
    go_to(12);
    n_vec++; if (reset_Aurora !== 2'b00) begin n_bad++; $display("FAIL aur_rel@12: got %b want 00", reset_Aurora); end
    go_to(20);
    channel_up = 2'b01;
    go_to(24);
    n_vec++; if ({link_ok, reset_TX_RX_Block} !== 4'b0011) begin n_bad++; $display("FAIL run_early@24: got %b want 0011", {link_ok, reset_TX_RX_Block}); end
    go_to(25);
    n_vec++; if ({link_ok, reset_TX_RX_Block} !== 4'b0110) begin n_bad++; $display("FAIL run@25: got %b want 0110", {link_ok, reset_TX_RX_Block}); end
    n_vec++; if (all_link_ok !== 1'b0) begin n_bad++; $display("FAIL all_ok@25: got %b want 0", all_link_ok); end
    go_to(61);
    n_vec++; if (gt_reset !== 2'b00) begin n_bad++; $display("FAIL retry1_early@61: got %b want 00", gt_reset); end
    go_to(62);
    n_vec++; if (gt_reset !== 2'b10) begin n_bad++; $display("FAIL retry1@62: got %b want 10", gt_reset); end
    go_to(66);
    n_vec++; if (gt_reset !== 2'b00) begin n_bad++; $display("FAIL retry1_rel@66: got %b want 00", gt_reset); end
    go_to(124);
    n_vec++; if (gt_reset !== 2'b10) begin n_bad++; $display("FAIL retry2@124: got %b want 10", gt_reset); end
    go_to(128);
    n_vec++; if (gt_reset !== 2'b00) begin n_bad++; $display("FAIL retry2_rel@128: got %b want 00", gt_reset); end
    go_to(185);
    n_vec++; if (init_fail !== 2'b00) begin n_bad++; $display("FAIL fail_early@185: got %b want 00", init_fail); end
    go_to(186);
    n_vec++; if (init_fail !== 2'b10) begin n_bad++; $display("FAIL fail@186: got %b want 10", init_fail); end
    n_vec++; if ({gt_reset, reset_Aurora, link_ok} !== 6'b101001) begin n_bad++; $display("FAIL fail_outs@186: got %b want 101001", {gt_reset, reset_Aurora, link_ok}); end
  endtask

  task automatic test_link_drop_glitch;
    go_to(200);
    channel_up = 2'b00;
    go_to(202);
    n_vec++; if (link_ok !== 2'b01) begin n_bad++; $display("FAIL drop_early@202: got %b want 01", link_ok); end
    go_to(203);
    n_vec++; if ({link_ok, gt_reset, reset_Aurora, reset_TX_RX_Block} !== 8'b00111111) begin n_bad++; $display("FAIL drop@203: got %b want 00111111", {link_ok, gt_reset, reset_Aurora, reset_TX_RX_Block}); end
    go_to(206);
    n_vec++; if (gt_reset !== 2'b11) begin n_bad++; $display("FAIL reinit_hold@206: got %b want 11", gt_reset); end
    go_to(207);
    n_vec++; if (gt_reset !== 2'b10) begin n_bad++; $display("FAIL reinit_rel@207: got %b want 10", gt_reset); end
    go_to(220);
    channel_up = 2'b01;
    go_to(222);
    channel_up = 2'b00;
    go_to(223);
    channel_up = 2'b01;
    go_to(225);
    n_vec++; if (reset_TX_RX_Block !== 2'b11) begin n_bad++; $display("FAIL glitch_hold@225: got %b want 11", reset_TX_RX_Block); end
    go_to(227);
    n_vec++; if (link_ok !== 2'b00) begin n_bad++; $display("FAIL glitch_early@227: got %b want 00", link_ok); end
    go_to(228);
    n_vec++; if (link_ok !== 2'b01) begin n_bad++; $display("FAIL glitch_run@228: got %b want 01", link_ok); end
  endtask

  task automatic test_reset_mid;
    go_to(240);
    RST = 1'b1;
    go_to(241);
    n_vec++; if ({gt_reset, reset_Aurora, reset_TX_RX_Block, link_ok, init_fail, all_link_ok} !== 11'b11111100000) begin
      n_bad++; $display("FAIL rst_run@241: got %b want 11111100000", {gt_reset, reset_Aurora, reset_TX_RX_Block, link_ok, init_fail, all_link_ok});
    end
    RST = 1'b0;
    go_to(244);
    n_vec++; if (gt_reset !== 2'b11) begin n_bad++; $display("FAIL rst1_hold@244: got %b want 11", gt_reset); end
    go_to(245);
    n_vec++; if (gt_reset !== 2'b00) begin n_bad++; $display("FAIL rst1_rel@245: got %b want 00", gt_reset); end
    go_to(248);
    RST = 1'b1;
    go_to(249);
    n_vec++; if ({gt_reset, reset_Aurora} !== 4'b1111) begin n_bad++; $display("FAIL rst_gtrel@249: got %b want 1111", {gt_reset, reset_Aurora}); end
    RST = 1'b0;
    go_to(253);
    n_vec++; if (gt_reset !== 2'b00) begin n_bad++; $display("FAIL rst2_rel@253: got %b want 00", gt_reset); end
    go_to(260);
    n_vec++; if (reset_Aurora !== 2'b11) begin n_bad++; $display("FAIL rst2_aur_hold@260: got %b want 11", reset_Aurora); end
    go_to(261);
    n_vec++; if (reset_Aurora !== 2'b00) begin n_bad++; $display("FAIL rst2_aur_rel@261: got %b want 00", reset_Aurora); end
    go_to(263);
    n_vec++; if (link_ok !== 2'b00) begin n_bad++; $display("FAIL rst2_early@263: got %b want 00", link_ok); end
    go_to(264);
    n_vec++; if (link_ok !== 2'b01) begin n_bad++; $display("FAIL rst2_run@264: got %b want 01", link_ok); end
    go_to(434);
    n_vec++; if (init_fail !== 2'b00) begin n_bad++; $display("FAIL fail2_early@434: got %b want 00", init_fail); end
    go_to(435);
    n_vec++; if ({init_fail, link_ok} !== 4'b1001) begin n_bad++; $display("FAIL fail2@435: got %b want 1001", {init_fail, link_ok}); end
    go_to(440);
    RST = 1'b1;
    go_to(441);
    n_vec++; if ({gt_reset, reset_Aurora, reset_TX_RX_Block, link_ok, init_fail, all_link_ok} !== 11'b11111100000) begin
      n_bad++; $display("FAIL rst_fail@441: got %b want 11111100000", {gt_reset, reset_Aurora, reset_TX_RX_Block, link_ok, init_fail, all_link_ok});
    end
    RST = 1'b0;
  endtask

  task automatic test_retry_clear;
    go_to(456);
    n_vec++; if (link_ok !== 2'b01) begin n_bad++; $display("FAIL rst3_run@456: got %b want 01", link_ok); end
    go_to(503);
    n_vec++; if (gt_reset !== 2'b10) begin n_bad++; $display("FAIL ch1_retry@503: got %b want 10", gt_reset); end
    go_to(510);
    channel_up = 2'b11;
    go_to(517);
    n_vec++; if ({link_ok, all_link_ok} !== 3'b010) begin n_bad++; $display("FAIL ch1_early@517: got %b want 010", {link_ok, all_link_ok}); end
    go_to(518);
    n_vec++; if ({link_ok, all_link_ok} !== 3'b111) begin n_bad++; $display("FAIL all_up@518: got %b want 111", {link_ok, all_link_ok}); end
    go_to(520);
    channel_up = 2'b01;
    go_to(522);
    n_vec++; if (link_ok !== 2'b11) begin n_bad++; $display("FAIL ch1_drop_early@522: got %b want 11", link_ok); end
    go_to(523);
    n_vec++; if ({link_ok, all_link_ok} !== 3'b010) begin n_bad++; $display("FAIL ch1_drop@523: got %b want 010", {link_ok, all_link_ok}); end
    go_to(708);
    n_vec++; if (init_fail !== 2'b00) begin n_bad++; $display("FAIL retry_cleared@708: got %b want 00", init_fail); end
    go_to(709);
    n_vec++; if ({init_fail, link_ok} !== 4'b1001) begin n_bad++; $display("FAIL fail3@709: got %b want 1001", {init_fail, link_ok}); end
  endtask

  initial begin
    test_reset();
    test_bringup_and_exhaust();
    test_link_drop_glitch();
    test_reset_mid();
    test_retry_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/aurora_init_multi.md
AURORA_INIT_MULTI -- requirements
Module: aurora_init_multi

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent Aurora channels.
REQ-002 SHALL have parameter GT_RST_CYC, default 128: cycles gt_reset is held after start of an attempt.
REQ-003 SHALL have parameter SYS_RST_CYC, default 256: cycles reset_Aurora is held after gt_reset release.
REQ-004 SHALL have parameter UP_TIMEOUT, default 65536: cycles to wait for channel_up before a retry.
REQ-005 SHALL have parameter STABLE_CYC, default 16: cycles channel_up must stay high before user logic is released.
REQ-006 SHALL have parameter MAX_RETRY, default 3: retries allowed before a channel is declared failed.
REQ-007 SHALL have port init_clk  in  1  single clock; all logic on its rising edge.
REQ-008 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-009 SHALL have port channel_up  in  N_CH  per-channel Aurora channel_up, asynchronous to init_clk.
REQ-010 SHALL have port gt_reset  out  N_CH  per-channel transceiver reset, active high.
REQ-011 SHALL have port reset_Aurora  out  N_CH  per-channel Aurora core reset, active high.
REQ-012 SHALL have port reset_TX_RX_Block  out  N_CH  per-channel user TX/RX logic reset, active high.
REQ-013 SHALL have port link_ok  out  N_CH  channel in RUN state.
REQ-014 SHALL have port init_fail  out  N_CH  channel in FAIL state.
REQ-015 SHALL have port all_link_ok  out  1  AND of all link_ok bits.

Function
REQ-016 SHALL pass each channel_up bit through a 2-flop synchronizer; every FSM decision uses the synchronized value.
REQ-017 SHALL run one independent FSM per channel with states RESET, GT_REL, WAIT_UP, STABLE, RUN, FAIL.
REQ-018 RESET: gt_reset=1, reset_Aurora=1, reset_TX_RX_Block=1; lasts exactly GT_RST_CYC cycles -> GT_REL.
REQ-019 GT_REL: gt_reset=0, others 1; lasts exactly SYS_RST_CYC cycles -> WAIT_UP.
REQ-020 WAIT_UP: reset_Aurora=0, reset_TX_RX_Block=1; synced channel_up=1 -> STABLE; UP_TIMEOUT cycles elapsed without it -> retry.
REQ-021 STABLE: channel_up high for STABLE_CYC consecutive cycles -> RUN; any low cycle -> WAIT_UP with timeout counter restarted.
REQ-022 RUN: reset_TX_RX_Block=0, link_ok=1; synced channel_up low -> RESET with retry counter cleared.
REQ-023 Retry: if retry count < MAX_RETRY, increment and go to RESET; otherwise -> FAIL.
REQ-024 FAIL: all three resets held at 1, init_fail=1; exits only on RST.
REQ-025 Cycle counters SHALL be sized $clog2 of the largest duration parameter plus 1 and SHALL never wrap; the retry counter saturates at MAX_RETRY.
REQ-026 Outputs SHALL be registered; state-to-output latency is zero cycles, i.e. outputs change on the same edge as the state.
REQ-027 Channels SHALL NOT interact; a failure or drop on one channel leaves the others unaffected.

Reset
REQ-028 On any edge with RST=1: all FSMs -> RESET; counters, retry counters and synchronizers cleared; gt_reset, reset_Aurora and reset_TX_RX_Block = all ones; link_ok, init_fail and all_link_ok = 0.
REQ-029 RST asserted mid-operation (any state, including FAIL) SHALL take effect on the next edge, with no completion of the current phase.
REQ-030 The first edge with RST=0 SHALL count as RESET cycle 1.

Structure
REQ-031 SHALL place the state enum and default parameter constants in shared package aurora_init_pkg.
REQ-032 SHALL implement the per-channel synchronizer and FSM in sub-module aurora_init_ch, instantiated N_CH times by generate.

Verification
Bench parameters: N_CH=2, GT_RST_CYC=4, SYS_RST_CYC=8, UP_TIMEOUT=50, STABLE_CYC=3, MAX_RETRY=2, init_clk period 8 ns.
REQ-033 SHALL verify nominal bring-up: RST high 50 cycles then low; channel_up[0] rises at edge 20 -> gt_reset[0] falls after edge 4, reset_Aurora[0] after edge 12, reset_TX_RX_Block[0] and link_ok[0] after edge 25.
REQ-034 SHALL verify the glitch case: channel_up[0] high 2 cycles, low 1 cycle, then high -> no release during the glitch; release 5 edges after the final rise.
REQ-035 SHALL verify retry exhaustion: channel_up[1] held 0 -> three attempts of 62 cycles each, with gt_reset[1] pulsing three times; init_fail[1]=1 after edge 186 and channel 0 unaffected.
REQ-036 SHALL verify link drop: channel_up[0] drops in RUN -> link_ok[0]=0 and all three resets high 3 edges later; re-init succeeds with retry counter cleared.
REQ-037 SHALL verify reset mid-operation: RST pulsed 1 cycle during GT_REL and again during FAIL -> all outputs at reset values on the next edge, then a full sequence restarts.
